// File: rtl/goboard_console_if.sv
// goboard_console_if: character stream handshake into the console.
// Signals: char_valid_i  - upstream has a character
//          char_data_i   - ASCII/control code
//          char_ready_o  - console can accept (transfer on valid & ready at a rising edge)
interface goboard_console_if;
    logic       char_valid_i;
    logic [7:0] char_data_i;
    logic       char_ready_o;
    modport master (output char_valid_i, char_data_i, input char_ready_o);
    modport slave (input char_valid_i, char_data_i, output char_ready_o);
endinterface

// File: rtl/goboard_console.sv
// goboard_console: character console that writes a COLS x ROWS info-panel RAM.
// Ports: sys_clk_in      - clock
//        arst_n_i        - asynchronous active-low reset
//        clear_i         - one-cycle request to blank the whole panel
//        chr             - character stream (valid/data/ready)
//        wea/ascii/write_ram_addr - registered info-RAM write port
//        cursor_row_o/cursor_col_o - current cursor
//        busy_o          - high whenever not idle
module goboard_console #(
    parameter int         COLS     = 16,
    parameter int         ROWS     = 32,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic                     sys_clk_in,
    input  logic                     arst_n_i,
    input  logic                     clear_i,
    goboard_console_if.slave         chr,
    output logic                     wea,
    output logic [7:0]               ascii,
    output logic [8:0]               write_ram_addr,
    output logic [4:0]               cursor_row_o,
    output logic [3:0]               cursor_col_o,
    output logic                     busy_o
);
    localparam logic [3:0] LAST_COL  = 4'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [8:0] LAST_ADDR = 9'(COLS * ROWS - 1);
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR_LINE, CLEAR_ALL} state_t;
    state_t     state;
    logic       boot;
    logic       pend;
    logic       nl;
    logic       accept;
    logic       printable;
    logic       wrap;
    logic [7:0] d;
    logic [8:0] base;
    logic [4:0] next_row;
    assign d         = chr.char_data_i;
    assign base      = 9'(cursor_row_o * COLS);
    assign next_row  = cursor_row_o == LAST_ROW ? 5'd0 : cursor_row_o + 5'd1;
    assign wrap      = cursor_col_o == LAST_COL;
    assign printable = d >= 8'h20 && d <= 8'h7E;
    // boot forces the power-up panel clear before the first character is taken
    assign chr.char_ready_o = state == IDLE && !boot && !pend && !clear_i;
    assign accept    = chr.char_valid_i && chr.char_ready_o;
    assign busy_o    = state != IDLE;
    always_ff @(posedge sys_clk_in or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state          <= IDLE;
            wea            <= 1'b0;
            ascii          <= 8'h00;
            write_ram_addr <= 9'd0;
            cursor_row_o   <= 5'd0;
            cursor_col_o   <= 4'd0;
            boot           <= 1'b1;
            pend           <= 1'b0;
            nl             <= 1'b0;
        end else begin
            pend <= state != IDLE && (pend || clear_i);
            wea  <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot || pend || clear_i) begin
                        state          <= CLEAR_ALL;
                        boot           <= 1'b0;
                        wea            <= 1'b1;
                        ascii          <= PAD_CHAR;
                        write_ram_addr <= 9'd0;
                    end else if (accept) begin
                        if (printable) begin
                            wea            <= 1'b1;
                            ascii          <= d;
                            write_ram_addr <= base + 9'(cursor_col_o);
                            cursor_col_o   <= wrap ? 4'd0 : cursor_col_o + 4'd1;
                            cursor_row_o   <= wrap ? next_row : cursor_row_o;
                            nl             <= wrap;
                            state          <= WRITE;
                        end else if (d == 8'h0A) begin
                            cursor_col_o <= 4'd0;
                            cursor_row_o <= next_row;
                            nl           <= 1'b1;
                            state        <= WRITE;
                        end else if (d == 8'h0D) begin
                            cursor_col_o <= 4'd0;
                        end else if (d == 8'h08 && cursor_col_o != 4'd0) begin
                            wea            <= 1'b1;
                            ascii          <= PAD_CHAR;
                            write_ram_addr <= base + 9'(cursor_col_o - 4'd1);
                            cursor_col_o   <= cursor_col_o - 4'd1;
                            nl             <= 1'b0;
                            state          <= WRITE;
                        end
                    end
                end
                // cursor already points at the new row, so base is the line to blank
                WRITE: begin
                    if (nl) begin
                        state          <= CLEAR_LINE;
                        wea            <= 1'b1;
                        ascii          <= PAD_CHAR;
                        write_ram_addr <= base;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR_LINE: begin
                    if (write_ram_addr == base + 9'(LAST_COL)) begin
                        state <= IDLE;
                    end else begin
                        wea            <= 1'b1;
                        write_ram_addr <= write_ram_addr + 9'd1;
                    end
                end
                CLEAR_ALL: begin
                    if (write_ram_addr == LAST_ADDR) begin
                        state        <= IDLE;
                        cursor_row_o <= 5'd0;
                        cursor_col_o <= 4'd0;
                    end else begin
                        wea            <= 1'b1;
                        write_ram_addr <= write_ram_addr + 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_goboard_console.sv
// tb_goboard_console: randomized and directed checks of goboard_console against a panel model.
module tb_goboard_console;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       wea;
    logic [7:0] ascii;
    logic [8:0] waddr;
    logic [4:0] crow;
    logic [3:0] ccol;
    logic       busy;
    goboard_console_if cif();
    goboard_console dut (
        .sys_clk_in(clk), .arst_n_i(rst_n), .clear_i(clear), .chr(cif.slave),
        .wea(wea), .ascii(ascii), .write_ram_addr(waddr),
        .cursor_row_o(crow), .cursor_col_o(ccol), .busy_o(busy)
    );
    always #5 clk = ~clk;
    typedef struct {int cyc; int addr; int data;} wr_t;
    wr_t got[$];
    wr_t exp[$];
    int total = 0;
    int bad = 0;
    int mrow = 0;
    int mcol = 0;
    int last_lat;
    logic [7:0] mmem [512];
    logic [7:0] dmem [512];
    always @(negedge clk) if (wea) dmem[waddr] = ascii;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    // records writes for up to maxc cycles after an edge; lat = first cycle ready is high
    task automatic collect(input int maxc, output int lat, output int r1, output int c1);
        lat = -1;
        r1 = -1;
        c1 = -1;
        for (int cyc = 1; cyc <= maxc; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                r1 = crow;
                c1 = ccol;
            end
            if (wea) got.push_back('{cyc, int'(waddr), int'(ascii)});
            if (cif.char_ready_o) begin
                lat = cyc;
                return;
            end
        end
    endtask
    function automatic bit clear_all_ok(input int off);
        if (got.size() != off + 512) return 1'b0;
        for (int i = 0; i < 512; i++)
            if (got[off+i].addr != i || got[off+i].data != 8'h20 || got[off+i].cyc != got[off].cyc + i) return 1'b0;
        return 1'b1;
    endfunction
    task automatic blank_row(input int base_cyc);
        for (int k = 0; k < 16; k++) begin
            exp.push_back('{base_cyc + k, mrow * 16 + k, 8'h20});
            mmem[mrow*16+k] = 8'h20;
        end
    endtask
    // panel behaviour from the character rules, independent of the RTL structure
    task automatic model_char(input logic [7:0] code, output int elat);
        exp.delete();
        if (code >= 8'h20 && code <= 8'h7E) begin
            exp.push_back('{1, mrow * 16 + mcol, int'(code)});
            mmem[mrow*16+mcol] = code;
            mcol++;
            if (mcol == 16) begin
                mcol = 0;
                mrow = (mrow + 1) % 32;
                blank_row(2);
                elat = 18;
            end else elat = 2;
        end else if (code == 8'h0A) begin
            mcol = 0;
            mrow = (mrow + 1) % 32;
            blank_row(2);
            elat = 18;
        end else if (code == 8'h0D) begin
            mcol = 0;
            elat = 1;
        end else if (code == 8'h08 && mcol > 0) begin
            mcol--;
            exp.push_back('{1, mrow * 16 + mcol, 8'h20});
            mmem[mrow*16+mcol] = 8'h20;
            elat = 2;
        end else elat = 1;
    endtask
    task automatic send(input logic [7:0] code);
        int n, lat, r1, c1, elat;
        bit ok;
        n = 0;
        while (!cif.char_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!cif.char_ready_o) begin
            bad++;
            $display("FAIL ready_wait code=%h ready=%b required=1", code, cif.char_ready_o);
            return;
        end
        cif.char_valid_i = 1'b1;
        cif.char_data_i = code;
        @(posedge clk);
        #1 cif.char_valid_i = 1'b0;
        model_char(code, elat);
        got.delete();
        collect(40, lat, r1, c1);
        last_lat = lat;
        total++;
        if (lat !== elat) begin
            bad++;
            $display("FAIL latency code=%h got=%0d required=%0d", code, lat, elat);
        end
        total++;
        if (r1 !== mrow || c1 !== mcol || crow !== 5'(mrow) || ccol !== 4'(mcol)) begin
            bad++;
            $display("FAIL cursor code=%h got=(%0d,%0d)/(%0d,%0d) required=(%0d,%0d)", code, r1, c1, crow, ccol, mrow, mcol);
        end
        ok = got.size() == exp.size();
        if (ok) foreach (exp[i]) if (got[i].cyc != exp[i].cyc || got[i].addr != exp[i].addr || got[i].data != exp[i].data) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL writes code=%h got_n=%0d required_n=%0d first_got_addr=%0d first_req_addr=%0d", code, got.size(), exp.size(),
                     got.size() > 0 ? got[0].addr : -1, exp.size() > 0 ? exp[0].addr : -1);
        end
    endtask
    task automatic test_reset();
        int lat, r1, c1;
        rst_n = 1'b0;
        #23;
        total++;
        if (wea !== 1'b0 || cif.char_ready_o !== 1'b0 || busy !== 1'b0 || crow !== 5'd0 || ccol !== 4'd0 || waddr !== 9'd0 || ascii !== 8'd0) begin
            bad++;
            $display("FAIL reset_state wea=%b ready=%b busy=%b cur=(%0d,%0d) addr=%0d ascii=%h required all zero", wea, cif.char_ready_o, busy, crow, ccol, waddr, ascii);
        end
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        collect(2000, lat, r1, c1);
        total++;
        if (!clear_all_ok(0) || lat == -1) begin
            bad++;
            $display("FAIL reset_clear writes=%0d lat=%0d required 512 ascending pad writes", got.size(), lat);
        end
        total++;
        if (crow !== 5'd0 || ccol !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_cursor cur=(%0d,%0d) busy=%b required (0,0) busy=0", crow, ccol, busy);
        end
        foreach (mmem[i]) mmem[i] = 8'h20;
        mrow = 0;
        mcol = 0;
    endtask
    task automatic test_char_a();
        send(8'h41);
        total++;
        if (got.size() < 1 || got[0].addr != 0 || got[0].data != 8'h41 || got[0].cyc != 1 || ccol !== 4'd1 || crow !== 5'd0 || last_lat != 2) begin
            bad++;
            $display("FAIL char_a n=%0d cur=(%0d,%0d) lat=%0d required addr=0 ascii=41 cur=(0,1) lat=2", got.size(), crow, ccol, last_lat);
        end
    endtask
    task automatic test_line16();
        send(8'h0D);
        repeat (3) send(8'h0A);
        for (int i = 0; i < 16; i++) send(8'($urandom_range(32, 126)));
        total++;
        if (got.size() != 17 || got[1].addr != 64 || got[16].addr != 79 || crow !== 5'd4 || ccol !== 4'd0) begin
            bad++;
            $display("FAIL line16 n=%0d cur=(%0d,%0d) required n=17 blank 64..79 cur=(4,0)", got.size(), crow, ccol);
        end
    endtask
    task automatic test_lf_wrap();
        while (mrow != 31) send(8'h0A);
        send(8'h0A);
        total++;
        if (got.size() != 16 || got[0].addr != 0 || got[15].addr != 15 || crow !== 5'd0 || ccol !== 4'd0) begin
            bad++;
            $display("FAIL lf_wrap n=%0d cur=(%0d,%0d) required blank 0..15 cur=(0,0)", got.size(), crow, ccol);
        end
    endtask
    task automatic test_backspace();
        send(8'h0D);
        repeat (2) send(8'h0A);
        repeat (5) send(8'($urandom_range(32, 126)));
        send(8'h08);
        total++;
        if (got.size() != 1 || got[0].addr != 36 || got[0].data != 8'h20 || ccol !== 4'd4) begin
            bad++;
            $display("FAIL bs_col5 n=%0d col=%0d required one write addr=36 ascii=20 col=4", got.size(), ccol);
        end
        send(8'h0D);
        send(8'h08);
        total++;
        if (got.size() != 0 || ccol !== 4'd0 || last_lat != 1) begin
            bad++;
            $display("FAIL bs_col0 n=%0d col=%0d lat=%0d required no write col=0 lat=1", got.size(), ccol, last_lat);
        end
    endtask
    task automatic test_random();
        logic [7:0] c;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: c = 8'h0A;
                1: c = 8'h0D;
                2: c = 8'h08;
                3: c = 8'($urandom_range(0, 255));
                default: c = 8'($urandom_range(32, 126));
            endcase
            send(c);
        end
    endtask
    task automatic test_clear_collapse();
        int lat, r;
        while (!cif.char_ready_o) @(negedge clk);
        r = (mrow + 1) % 32;
        cif.char_valid_i = 1'b1;
        cif.char_data_i = 8'h0A;
        @(posedge clk);
        #1 cif.char_valid_i = 1'b0;
        got.delete();
        lat = -1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (wea) got.push_back('{cyc, int'(waddr), int'(ascii)});
            if (cif.char_ready_o) begin
                lat = cyc;
                break;
            end
            clear = cyc == 4 || cyc == 8;
        end
        clear = 1'b0;
        total++;
        if (lat == -1 || got.size() != 528 || got[0].addr != r * 16 || got[15].addr != r * 16 + 15 || !clear_all_ok(16)) begin
            bad++;
            $display("FAIL clear_collapse writes=%0d lat=%0d required 16 line + 512 clear writes", got.size(), lat);
        end
        total++;
        if (crow !== 5'd0 || ccol !== 4'd0) begin
            bad++;
            $display("FAIL clear_collapse_cursor cur=(%0d,%0d) required (0,0)", crow, ccol);
        end
        foreach (mmem[i]) mmem[i] = 8'h20;
        mrow = 0;
        mcol = 0;
    endtask
    task automatic test_clear_vs_char();
        int lat, r1, c1;
        send(8'h41);
        clear = 1'b1;
        cif.char_valid_i = 1'b1;
        cif.char_data_i = 8'h5A;
        #1;
        total++;
        if (cif.char_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL clear_vs_char_ready ready=%b required 0", cif.char_ready_o);
        end
        @(posedge clk);
        #1 clear = 1'b0;
        cif.char_valid_i = 1'b0;
        got.delete();
        collect(2000, lat, r1, c1);
        total++;
        if (!clear_all_ok(0) || lat == -1 || crow !== 5'd0 || ccol !== 4'd0) begin
            bad++;
            $display("FAIL clear_vs_char writes=%0d cur=(%0d,%0d) required 512 pad writes cur=(0,0)", got.size(), crow, ccol);
        end
        foreach (mmem[i]) mmem[i] = 8'h20;
        mrow = 0;
        mcol = 0;
    endtask
    task automatic test_reset_abort();
        int lat, r1, c1, n;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (wea !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_now wea=%b busy=%b required 0 0", wea, busy);
        end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (wea) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL abort_hold wea_pulses=%0d required 0", n);
        end
        rst_n = 1'b1;
        got.delete();
        collect(2000, lat, r1, c1);
        total++;
        if (!clear_all_ok(0) || lat == -1) begin
            bad++;
            $display("FAIL abort_reclear writes=%0d lat=%0d required 512 pad writes", got.size(), lat);
        end
        foreach (mmem[i]) mmem[i] = 8'h20;
        mrow = 0;
        mcol = 0;
    endtask
    task automatic test_memory();
        int n;
        n = 0;
        foreach (mmem[i]) if (dmem[i] !== mmem[i]) n++;
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL panel_contents differing_cells=%0d required 0", n);
        end
    endtask
    initial begin
        cif.char_valid_i = 1'b0;
        cif.char_data_i = 8'h00;
        test_reset();
        test_char_a();
        test_line16();
        test_lf_wrap();
        test_backspace();
        test_random();
        test_memory();
        test_clear_collapse();
        test_clear_vs_char();
        test_random();
        test_memory();
        test_reset_abort();
        test_random();
        test_memory();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/goboard_console.md
GOBOARD_CONSOLE -- requirements
Module: goboard_console

Interface
REQ-001 The parameters SHALL be COLS, default 16, characters per info-panel row.
REQ-002 The parameters SHALL include ROWS, default 32, rows in the info RAM (COLS*ROWS = 512 = 9-bit address space).
REQ-003 The parameters SHALL include PAD_CHAR, default 8'h20, the blanking character.
REQ-004 The design SHALL use one clock and an asynchronous, active-low reset: sys_clk_in input 1 is the clock; arst_n_i input 1 is the reset, active low.
REQ-005 char_valid_i input 1: the upstream character is valid.
REQ-006 char_data_i input 8: the ASCII/control code.
REQ-007 char_ready_o output 1: the character is accepted when char_valid_i & char_ready_o are both high at a rising edge.
REQ-008 clear_i input 1: a single-cycle request to blank the whole panel.
REQ-009 wea output 1: the info-RAM write enable.
REQ-010 ascii output 8: the info-RAM write data.
REQ-011 write_ram_addr output 9: the info-RAM write address, equal to row*COLS+col.
REQ-012 cursor_row_o output 5: the current row.
REQ-013 cursor_col_o output 4: the current column.
REQ-014 busy_o output 1: high whenever the state is not IDLE.

Function
REQ-015 The state machine SHALL have states IDLE, WRITE, CLEAR_LINE and CLEAR_ALL; wea, ascii and write_ram_addr SHALL be registered.
REQ-016 char_ready_o SHALL be high only in IDLE with no pending clear and clear_i low (combinational on clear_i).
REQ-017 A printable code (8'h20..8'h7E) accepted at edge N SHALL produce wea=1, ascii=code and write_ram_addr=row*16+col during cycle N+1, lasting exactly one cycle.
REQ-018 After a printable write, col SHALL increment; at col=15 it SHALL become 0, row SHALL increment, and the new row SHALL be cleared.
REQ-019 Row increment SHALL wrap from 31 to 0.
REQ-020 LF (8'h0A) SHALL set col=0, advance the row (with wrap), and clear the new row.
REQ-021 CR (8'h0D) SHALL set col=0 with no write and no row change.
REQ-022 BS (8'h08) with col>0 SHALL set col=col-1 and write PAD_CHAR at the new position; with col=0 it SHALL do nothing.
REQ-023 All other codes SHALL be accepted and dropped, with no write and no cursor change.
REQ-024 CLEAR_LINE SHALL write PAD_CHAR to row*16+0..15 over 16 consecutive cycles (wea high each cycle), then return to IDLE.
REQ-025 CLEAR_ALL SHALL write PAD_CHAR to addresses 0..511 in ascending order over 512 consecutive cycles, then set the cursor to (0,0) and return to IDLE.
REQ-026 clear_i in IDLE SHALL enter CLEAR_ALL on the next edge.
REQ-027 clear_i outside IDLE SHALL be latched as pending and executed immediately after the current operation ends.
REQ-028 Multiple clear_i pulses while pending SHALL collapse to one clear.
REQ-029 clear_i coincident with char_valid_i in IDLE: the clear SHALL win and the character SHALL NOT be accepted (char_ready_o low).
REQ-030 From acceptance to next char_ready_o high SHALL be: printable without line wrap = 2 cycles; printable with wrap or LF = 2+16 cycles; CR, BS at col 0, or dropped code = 1 cycle.
REQ-031 Cursor outputs SHALL update on the same edge the corresponding write is issued.

Reset
REQ-032 When arst_n_i is low, the block SHALL asynchronously set state=IDLE, wea=0, ascii=0, write_ram_addr=0, cursor=(0,0), pending clear=0, char_ready_o=0, busy_o=0.
REQ-033 On the first edge after arst_n_i rises, the block SHALL enter CLEAR_ALL automatically, with char_ready_o low until that clear completes.
REQ-034 Reset asserted mid-operation SHALL abort the operation immediately, with no further wea pulses until after release.

Verification
REQ-035 Release reset -> exactly 512 wea pulses, addresses 0..511, ascii=8'h20; then char_ready_o=1 and cursor=(0,0).
REQ-036 Send "A" (8'h41) at cursor (0,0) -> next cycle wea=1, addr=0, ascii=8'h41; cursor=(0,1); char_ready_o high again 2 cycles after acceptance.
REQ-037 Send 16 printable characters from (3,0) -> writes to addresses 48..63, then 16 blanking writes to 64..79, then cursor=(4,0).
REQ-038 At row 31, send LF -> cursor=(0,0) and addresses 0..15 are blanked.
REQ-039 Send BS at col 5 on row 2 -> one write addr=36, ascii=8'h20, col=4; send BS at col 0 -> no wea pulse.
REQ-040 Pulse clear_i during CLEAR_LINE, together with a second clear_i pulse -> the line clear completes, then exactly one 512-write CLEAR_ALL runs; clear_i and char_valid_i asserted together in IDLE -> the character is not accepted.
